// File: rtl/sfp_txdis_ctrl_pkg.sv
// sfp_txdis_ctrl shared types: per-port state encodings and default tick counts.
// Optional ALS logic is built only when SFP_ALS_EN is defined.
package sfp_txdis_ctrl_pkg;

  localparam int DEF_NUM_PORTS   = 8;
  localparam int DEF_CNT_W       = 14;
  localparam int DEF_INS_TICKS   = 50;
  localparam int DEF_LOS_TICKS   = 50;
  localparam int DEF_REST_TICKS  = 10000;
  localparam int DEF_PROBE_TICKS = 200;

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_INS_WAIT = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_LOS_WAIT = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_PROBE    = 3'd5
  } port_state_t;

  function automatic logic pin_of(port_state_t s);
    return (s == ST_ABSENT) || (s == ST_INS_WAIT) ||
           (s == ST_SHUTDOWN);
  endfunction

  function automatic logic is_timed(port_state_t s);
    return (s == ST_INS_WAIT) || (s == ST_LOS_WAIT) ||
           (s == ST_SHUTDOWN) || (s == ST_PROBE);
  endfunction

endpackage

// File: rtl/sfp_txdis_ctrl_if.sv
// sfp_txdis_ctrl status/control bundle between the SFP status block and
// the TX_DISABLE controller.
interface sfp_txdis_ctrl_if #(
  parameter int NUM_PORTS = 8
);
  logic [NUM_PORTS-1:0] sfp_only_reg;
  logic [NUM_PORTS-1:0] sfp_los_reg;
  logic [NUM_PORTS-1:0] txdis_force;
  logic [NUM_PORTS-1:0] als_restart;
  logic [NUM_PORTS-1:0] sfp_txdis_pin;
  logic [NUM_PORTS-1:0] als_status;

  modport master (
    output sfp_only_reg,
    output sfp_los_reg,
    output txdis_force,
    output als_restart,
    input  sfp_txdis_pin,
    input  als_status
  );

  modport slave (
    input  sfp_only_reg,
    input  sfp_los_reg,
    input  txdis_force,
    input  als_restart,
    output sfp_txdis_pin,
    output als_status
  );
endinterface

// File: rtl/sfp_txdis_port.sv
// sfp_txdis_port: single-cage TX_DISABLE FSM with saturating tick counter.
// LOS_WAIT/SHUTDOWN/PROBE exist only when SFP_ALS_EN is defined.
module sfp_txdis_port
  import sfp_txdis_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int INS_TICKS   = DEF_INS_TICKS,
  parameter int LOS_TICKS   = DEF_LOS_TICKS,
  parameter int REST_TICKS  = DEF_REST_TICKS,
  parameter int PROBE_TICKS = DEF_PROBE_TICKS
) (
  input  logic clk_100hz,
  input  logic rst_n,
  input  logic absent,
  input  logic los,
  input  logic force_off,
  input  logic restart,
  output logic pin,
  output logic als
);

  localparam longint MAX_TICKS = longint'(1) << CNT_W;

  if (INS_TICKS <= 0 || longint'(INS_TICKS) > MAX_TICKS) begin : g_bad_ins
    $error("INS_TICKS out of range");
  end
  if (LOS_TICKS <= 0 || longint'(LOS_TICKS) > MAX_TICKS) begin : g_bad_los
    $error("LOS_TICKS out of range");
  end
  if (REST_TICKS <= 0 || longint'(REST_TICKS) > MAX_TICKS) begin : g_bad_rest
    $error("REST_TICKS out of range");
  end
  if (PROBE_TICKS <= 0 || longint'(PROBE_TICKS) > MAX_TICKS) begin : g_bad_probe
    $error("PROBE_TICKS out of range");
  end

  localparam logic [CNT_W-1:0] INS_LAST = CNT_W'(INS_TICKS - 1);

  port_state_t      state;
  port_state_t      state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             pin_q;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef SFP_ALS_EN
  localparam logic [CNT_W-1:0] LOS_LAST   = CNT_W'(LOS_TICKS - 1);
  localparam logic [CNT_W-1:0] REST_LAST  = CNT_W'(REST_TICKS - 1);
  localparam logic [CNT_W-1:0] PROBE_LAST = CNT_W'(PROBE_TICKS - 1);
`else
  logic unused_als_in;
  assign unused_als_in = los ^ restart;
`endif

  always_comb begin
    state_n = state;
    priority case (1'b1)
      absent:    state_n = ST_ABSENT;
      force_off: state_n = ST_INS_WAIT;
      default: begin
        case (state)
          ST_ABSENT:   state_n = ST_INS_WAIT;
          ST_INS_WAIT: if (cnt == INS_LAST) state_n = ST_ACTIVE;
`ifdef SFP_ALS_EN
          ST_ACTIVE:   if (los) state_n = ST_LOS_WAIT;
          ST_LOS_WAIT: begin
            if (!los)                  state_n = ST_ACTIVE;
            else if (cnt == LOS_LAST)  state_n = ST_SHUTDOWN;
          end
          ST_SHUTDOWN: begin
            if (restart || cnt == REST_LAST) state_n = ST_PROBE;
          end
          ST_PROBE: begin
            if (!los)                    state_n = ST_ACTIVE;
            else if (cnt == PROBE_LAST)  state_n = ST_SHUTDOWN;
          end
`else
          ST_ACTIVE:   state_n = ST_ACTIVE;
`endif
          default:     state_n = ST_ABSENT;
        endcase
      end
    endcase
  end

  // Counter restarts on every state entry and is pinned at 0 while forced
  always_comb begin
    cnt_n = cnt_inc;
    if (!is_timed(state_n) || state_n != state || force_off)
      cnt_n = '0;
  end

  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ABSENT;
      cnt   <= '0;
      pin_q <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pin_q <= pin_of(state_n);
    end
  end

  assign pin = pin_q;

`ifdef SFP_ALS_EN
  logic als_q;

  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n) als_q <= 1'b0;
    else        als_q <= (state_n == ST_SHUTDOWN) ||
                         (state_n == ST_PROBE);
  end

  assign als = als_q;
`else
  assign als = 1'b0;
`endif

endmodule

// File: rtl/sfp_txdis_ctrl.sv
// sfp_txdis_ctrl: per-cage SFP TX_DISABLE control, one FSM per port.
// Define SFP_ALS_EN to build automatic laser shutdown.
module sfp_txdis_ctrl
  import sfp_txdis_ctrl_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int INS_TICKS   = DEF_INS_TICKS,
  parameter int LOS_TICKS   = DEF_LOS_TICKS,
  parameter int REST_TICKS  = DEF_REST_TICKS,
  parameter int PROBE_TICKS = DEF_PROBE_TICKS
) (
  input logic               clk_100hz,
  input logic               rst_n,
  sfp_txdis_ctrl_if.slave   bus
);

  logic [NUM_PORTS-1:0] pin_w;
  logic [NUM_PORTS-1:0] als_w;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    sfp_txdis_port #(
      .CNT_W       (CNT_W),
      .INS_TICKS   (INS_TICKS),
      .LOS_TICKS   (LOS_TICKS),
      .REST_TICKS  (REST_TICKS),
      .PROBE_TICKS (PROBE_TICKS)
    ) u_port (
      .clk_100hz (clk_100hz),
      .rst_n     (rst_n),
      .absent    (bus.sfp_only_reg[i]),
      .los       (bus.sfp_los_reg[i]),
      .force_off (bus.txdis_force[i]),
      .restart   (bus.als_restart[i]),
      .pin       (pin_w[i]),
      .als       (als_w[i])
    );
  end

  assign bus.sfp_txdis_pin = pin_w;
  assign bus.als_status    = als_w;

endmodule
